// File: rtl/capture_pkg.sv
// Shared definitions for the capture sequencer: state encoding,
// bus register map and CTRL register bit positions.
package capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } cap_state_e;

    // Word addresses on the write-only system bus
    localparam int ADR_CTRL = 0;
    localparam int ADR_PRE  = 1;
    localparam int ADR_POST = 2;
    localparam int ADR_MASK = 3;

    // CTRL register strobe bits
    localparam int CTRL_ARM   = 0;
    localparam int CTRL_ABORT = 1;

endpackage

// File: rtl/str_reg.sv
// One-entry registered stream stage carrying a sample plus trigger/last
// markers. Accepts a new beat whenever it is empty or being drained, so
// it sustains one beat per cycle; the held beat never changes while stalled.
module str_reg #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          trig_i,
    input  logic          last_i,
    output logic          ready_o,
    input  logic          out_ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          trig_o,
    output logic          last_o
);

    logic          valid_q;
    logic [DW-1:0] data_q;
    logic          trig_q;
    logic          last_q;

    assign ready_o = ~valid_q | out_ready_i;

    // Load a new beat, or retire the held one once the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            trig_q  <= 1'b0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            trig_q  <= trig_i;
            last_q  <= last_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign trig_o  = trig_q;
    assign last_o  = last_q;

endmodule

// File: rtl/capture_ctl.sv
// Capture sequencer: gates the trigger block's output stream into sample
// storage. Pre-trigger fill, wait for a masked event, post-trigger count,
// then stop. Programmed through a small write-only register file.
module capture_ctl
    import capture_pkg::*;
#(
    parameter int BAW = 8,
    parameter int BDW = 32,
    parameter int SDW = 32,
    parameter int SEW = 32,
    parameter int CCW = 32
) (
    input  logic           clk,
    input  logic           rst,
    output logic           bus_wready,
    input  logic           bus_wvalid,
    input  logic [BAW-1:0] bus_waddr,
    input  logic [BDW-1:0] bus_wdata,
    output logic           sti_tready,
    input  logic           sti_tvalid,
    input  logic [SEW-1:0] sti_tevent,
    input  logic [SDW-1:0] sti_tdata,
    input  logic           sto_tready,
    output logic           sto_tvalid,
    output logic           sto_ttrig,
    output logic           sto_tlast,
    output logic [SDW-1:0] sto_tdata,
    output logic [2:0]     cap_state,
    output logic           cap_done
);

    // Programmed registers (bus-visible) and the copies a capture runs from
    logic [CCW-1:0] pre_q;
    logic [CCW-1:0] post_q;
    logic [SEW-1:0] mask_q;
    logic [CCW-1:0] post_s_q;
    logic [SEW-1:0] mask_s_q;

    cap_state_e     state_q;
    logic [CCW-1:0] cnt_q;
    logic           done_q;

    logic wr_ctrl;
    logic arm;
    logic abort;
    logic capturing;
    logic stage_ready;
    logic xfer;
    logic hit;
    logic beat_trig;
    logic beat_last;

    assign bus_wready = 1'b1;

    assign wr_ctrl = bus_wvalid && (bus_waddr == BAW'(ADR_CTRL));
    assign arm     = wr_ctrl && bus_wdata[CTRL_ARM];
    assign abort   = wr_ctrl && bus_wdata[CTRL_ABORT];

    assign capturing = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);

    // Outside a capture the trigger is never stalled; samples are simply dropped
    assign sti_tready = capturing ? stage_ready : 1'b1;

    // A sample arriving in the same cycle as ABORT is dropped with the capture
    assign xfer = sti_tvalid && sti_tready && capturing && !abort;
    assign hit  = |(sti_tevent & mask_s_q);

    // Register file writes; writes mid-capture only affect the next ARM
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            post_q <= '0;
            mask_q <= '0;
        end else if (bus_wvalid) begin
            if (bus_waddr == BAW'(ADR_PRE))  pre_q  <= bus_wdata[CCW-1:0];
            if (bus_waddr == BAW'(ADR_POST)) post_q <= bus_wdata[CCW-1:0];
            if (bus_waddr == BAW'(ADR_MASK)) mask_q <= bus_wdata[SEW-1:0];
        end
    end

    // Markers attached to the beat being forwarded this cycle
    always_comb begin
        beat_trig = 1'b0;
        beat_last = 1'b0;
        case (state_q)
            ST_ARMED: begin
                if (hit) begin
                    beat_trig = 1'b1;
                    beat_last = (post_s_q == '0);
                end
            end
            ST_POST:  beat_last = (cnt_q == CCW'(1));
            default: ;
        endcase
    end

    // Sequencer: state, down-counter, shadow copies and the done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            post_s_q <= '0;
            mask_s_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (arm) begin
                            post_s_q <= post_q;
                            mask_s_q <= mask_q;
                            cnt_q    <= pre_q;
                            state_q  <= (pre_q == '0) ? ST_ARMED : ST_PRE;
                        end
                    end
                    ST_PRE: begin
                        if (xfer) begin
                            if (cnt_q != '0) cnt_q <= cnt_q - CCW'(1);
                            if (cnt_q == CCW'(1)) state_q <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (xfer && hit) begin
                            if (post_s_q == '0) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                cnt_q   <= post_s_q;
                                state_q <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        if (xfer) begin
                            if (cnt_q != '0) cnt_q <= cnt_q - CCW'(1);
                            if (cnt_q == CCW'(1)) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    str_reg #(
        .DW (SDW)
    ) u_out (
        .clk         (clk),
        .rst         (rst),
        .load_i      (xfer),
        .data_i      (sti_tdata),
        .trig_i      (beat_trig),
        .last_i      (beat_last),
        .ready_o     (stage_ready),
        .out_ready_i (sto_tready),
        .valid_o     (sto_tvalid),
        .data_o      (sto_tdata),
        .trig_o      (sto_ttrig),
        .last_o      (sto_tlast)
    );

    assign cap_state = state_q;
    assign cap_done  = done_q;

endmodule

// File: tb/tb_capture_ctl.sv
// Self-checking bench for capture_ctl: directed scenarios plus random
// traffic, compared every cycle against a beat-counting reference model.
module tb_capture_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_wready;
    logic        bus_wvalid;
    logic [7:0]  bus_waddr;
    logic [31:0] bus_wdata;
    logic        sti_tready;
    logic        sti_tvalid;
    logic [31:0] sti_tevent;
    logic [31:0] sti_tdata;
    logic        sto_tready;
    logic        sto_tvalid;
    logic        sto_ttrig;
    logic        sto_tlast;
    logic [31:0] sto_tdata;
    logic [2:0]  cap_state;
    logic        cap_done;

    capture_ctl dut (
        .clk        (clk),
        .rst        (rst),
        .bus_wready (bus_wready),
        .bus_wvalid (bus_wvalid),
        .bus_waddr  (bus_waddr),
        .bus_wdata  (bus_wdata),
        .sti_tready (sti_tready),
        .sti_tvalid (sti_tvalid),
        .sti_tevent (sti_tevent),
        .sti_tdata  (sti_tdata),
        .sto_tready (sto_tready),
        .sto_tvalid (sto_tvalid),
        .sto_ttrig  (sto_ttrig),
        .sto_tlast  (sto_tlast),
        .sto_tdata  (sto_tdata),
        .cap_state  (cap_state),
        .cap_done   (cap_done)
    );

    always #5 clk = ~clk;

    // Reference model: a capture is described by how many beats it has
    // forwarded before and after the trigger, not by a state machine.
    typedef struct {
        logic [31:0] d;
        bit          t;
        bit          l;
    } beat_t;

    beat_t       m_q[$];
    int unsigned m_reg_pre = 0, m_reg_post = 0;
    logic [31:0] m_reg_mask = '0;
    bit          m_active = 0, m_done = 0, m_trig = 0, m_done_pulse = 0;
    int unsigned m_pre = 0, m_post = 0, m_npre = 0, m_npost = 0;
    logic [31:0] m_mask = '0;

    // Beats actually delivered by the DUT
    logic [31:0] log_d[$];
    bit          log_t[$];
    bit          log_l[$];
    int          done_cnt = 0;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_state();
        if (!m_active) return m_done ? 4 : 0;
        if (m_npre < m_pre) return 1;
        if (!m_trig) return 2;
        return 3;
    endfunction

    function automatic bit exp_ready(input bit tr);
        if (!m_active) return 1'b1;
        return (m_q.size() == 0) || tr;
    endfunction

    task automatic model_push(input logic [31:0] d, input bit t, input bit l);
        beat_t b;
        b.d = d;
        b.t = t;
        b.l = l;
        m_q.push_back(b);
        if (l) begin
            m_active     = 0;
            m_done       = 1;
            m_done_pulse = 1;
        end
    endtask

    // One clock cycle: drive inputs just after a falling edge, advance the
    // model at the rising edge, check registered outputs at the next fall.
    task automatic step(input bit wv, input int addr, input logic [31:0] wd,
                        input bit sv, input logic [31:0] ev, input logic [31:0] sd,
                        input bit tr, input bit r);
        bit xfer, consume, was_active, abort, arm;
        rst        = r;
        bus_wvalid = wv;
        bus_waddr  = addr[7:0];
        bus_wdata  = wd;
        sti_tvalid = sv;
        sti_tevent = ev;
        sti_tdata  = sd;
        sto_tready = tr;
        #1;
        check("sti_tready", sti_tready, exp_ready(tr));
        xfer    = sv && exp_ready(tr);
        consume = (m_q.size() > 0) && tr;
        if (sto_tvalid && sto_tready) begin
            log_d.push_back(sto_tdata);
            log_t.push_back(sto_ttrig);
            log_l.push_back(sto_tlast);
        end
        @(posedge clk);
        m_done_pulse = 0;
        if (r) begin
            m_q.delete();
            m_reg_pre = 0; m_reg_post = 0; m_reg_mask = '0;
            m_active = 0; m_done = 0; m_trig = 0;
            m_pre = 0; m_post = 0; m_npre = 0; m_npost = 0; m_mask = '0;
        end else begin
            if (consume) void'(m_q.pop_front());
            was_active = m_active;
            abort = wv && (addr == 0) && wd[1];
            arm   = wv && (addr == 0) && wd[0];
            if (wv && addr == 1) m_reg_pre  = wd;
            if (wv && addr == 2) m_reg_post = wd;
            if (wv && addr == 3) m_reg_mask = wd;
            if (abort) begin
                m_active = 0;
                m_done   = 0;
            end else if (arm && !was_active) begin
                m_active = 1; m_done = 0; m_trig = 0;
                m_pre = m_reg_pre; m_post = m_reg_post; m_mask = m_reg_mask;
                m_npre = 0; m_npost = 0;
            end else if (xfer && was_active) begin
                if (m_npre < m_pre) begin
                    m_npre++;
                    model_push(sd, 0, 0);
                end else if (!m_trig) begin
                    if ((ev & m_mask) != 0) begin
                        m_trig = 1;
                        model_push(sd, 1, m_post == 0);
                    end else begin
                        model_push(sd, 0, 0);
                    end
                end else begin
                    m_npost++;
                    model_push(sd, 0, m_npost == m_post);
                end
            end
        end
        @(negedge clk);
        if (cap_done === 1'b1) done_cnt++;
        check("cap_state", cap_state, exp_state());
        check("cap_done", cap_done, m_done_pulse);
        check("bus_wready", bus_wready, 1);
        check("sto_tvalid", sto_tvalid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            check("sto_tdata", sto_tdata, m_q[0].d);
            check("sto_ttrig", sto_ttrig, m_q[0].t);
            check("sto_tlast", sto_tlast, m_q[0].l);
        end
    endtask

    task automatic wr(input int addr, input logic [31:0] data);
        step(1, addr, data, 0, 0, 0, 1, 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic sample(input logic [31:0] d, input logic [31:0] ev, input bit tr);
        step(0, 0, 0, 1, ev, d, tr, 0);
    endtask

    task automatic clear_log();
        log_d.delete();
        log_t.delete();
        log_l.delete();
        done_cnt = 0;
    endtask

    // PRE=3 POST=2 MASK=1, samples 0..9 with the event on sample 5
    task automatic run_t1(input bit stall);
        int i, cyc;
        bit tr, rdy;
        wr(1, 3); wr(2, 2); wr(3, 1);
        clear_log();
        wr(0, 1);
        i = 0;
        cyc = 0;
        while (i < 10 && cyc < 200) begin
            tr  = stall ? (cyc % 3 == 0) : 1'b1;
            rdy = exp_ready(tr);
            sample(i, (i == 5) ? 32'h1 : 32'h0, tr);
            if (rdy) i++;
            cyc++;
        end
        check("t1_budget", i, 10);
        idle(4);
        check("t1_nbeats", log_d.size(), 8);
        for (int k = 0; k < 8 && k < log_d.size(); k++) begin
            check("t1_data", log_d[k], k);
            check("t1_trig", log_t[k], k == 5);
            check("t1_last", log_l[k], k == 7);
        end
        check("t1_done_cnt", done_cnt, 1);
        check("t1_state", cap_state, 4);
    endtask

    initial begin
        rst = 1; bus_wvalid = 0; bus_waddr = 0; bus_wdata = 0;
        sti_tvalid = 0; sti_tevent = 0; sti_tdata = 0; sto_tready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", cap_state, 0);
        check("rst_tvalid", sto_tvalid, 0);
        check("rst_tdata", sto_tdata, 0);
        check("rst_done", cap_done, 0);
        check("rst_wready", bus_wready, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1);

        // Basic capture, then the same with output back-pressure
        run_t1(0);
        run_t1(1);

        // Zero-length pre and post: the trigger beat is also the last
        wr(1, 0); wr(2, 0); wr(3, 1);
        clear_log();
        wr(0, 1);
        check("t2_armed", cap_state, 2);
        sample(32'hAA, 32'h1, 1);
        check("t2_state", cap_state, 4);
        check("t2_done", cap_done, 1);
        idle(2);
        check("t2_nbeats", log_d.size(), 1);
        if (log_d.size() == 1) begin
            check("t2_data", log_d[0], 32'hAA);
            check("t2_trig", log_t[0], 1);
            check("t2_last", log_l[0], 1);
        end

        // ABORT with a beat stuck in the output stage
        wr(1, 0); wr(2, 5); wr(3, 1);
        clear_log();
        wr(0, 1);
        sample(32'h40, 32'h0, 0);
        step(1, 0, 32'h2, 0, 0, 0, 0, 0);
        check("t4_state", cap_state, 0);
        check("t4_pending", sto_tvalid, 1);
        for (int k = 0; k < 4; k++) sample(32'h50 + k, 32'h1, 1);
        check("t4_nbeats", log_d.size(), 1);
        if (log_d.size() == 1) check("t4_data", log_d[0], 32'h40);
        check("t4_done_cnt", done_cnt, 0);
        wr(0, 3);
        check("t4_armabort", cap_state, 0);

        // Masked-out event, event during PRE, POST rewrite mid-capture
        wr(1, 2); wr(2, 3); wr(3, 2);
        clear_log();
        wr(0, 1);
        sample(0, 32'h2, 1);
        sample(1, 32'h2, 1);
        check("t5_pre_ignored", cap_state, 2);
        sample(2, 32'h1, 1);
        check("t5_masked", cap_state, 2);
        sample(3, 32'h2, 1);
        check("t5_post", cap_state, 3);
        wr(2, 100);
        for (int k = 4; k < 9; k++) sample(k, 32'h0, 1);
        idle(2);
        check("t5_nbeats", log_d.size(), 7);
        for (int k = 0; k < 7 && k < log_d.size(); k++) begin
            check("t5_data", log_d[k], k);
            check("t5_trig", log_t[k], k == 3);
            check("t5_last", log_l[k], k == 6);
        end

        // Reset mid-capture with a held beat, then a fresh capture
        wr(1, 1); wr(2, 10); wr(3, 1);
        wr(0, 1);
        sample(32'h11, 0, 1);
        sample(32'h22, 1, 1);
        sample(32'h33, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("t6_tvalid", sto_tvalid, 0);
        check("t6_ttrig", sto_ttrig, 0);
        check("t6_tlast", sto_tlast, 0);
        check("t6_tdata", sto_tdata, 0);
        check("t6_state", cap_state, 0);
        check("t6_done", cap_done, 0);
        run_t1(0);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            bit          wv, sv, tr, r;
            int          addr;
            logic [31:0] wd, ev;
            wv   = ($urandom % 8) == 0;
            addr = $urandom % 5;
            if (addr == 0) wd = {30'd0, ($urandom % 6) == 0, 1'($urandom % 2)};
            else if (addr == 3) wd = $urandom % 16;
            else wd = $urandom % 6;
            sv = ($urandom % 4) != 0;
            ev = (($urandom % 4) == 0) ? ($urandom % 16) : 32'h0;
            tr = ($urandom % 4) != 0;
            r  = ($urandom % 700) == 0;
            step(wv, addr, wd, sv, ev, $urandom, tr, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
